// File: rtl/obi_mux_qos.sv
// OBI N:1 multiplexer with round-robin or fixed-priority arbitration, per-port outstanding limits and response routing FIFO.
// Optional per-port grant counters are enabled with `define OBI_MUX_QOS_PERF_CNT_EN.
package obi_pkg;
   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
      bit          UseRReady;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1, UseRReady: 1'b0};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      obi_a_chan_t a;
      logic        req;
      logic        rready;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      obi_r_chan_t r;
      logic        gnt;
      logic        rvalid;
   } obi_rsp_t;
endpackage

module obi_mux_qos #(
   parameter obi_pkg::obi_cfg_t SbrPortObiCfg = obi_pkg::ObiDefaultConfig,
   parameter obi_pkg::obi_cfg_t MgrPortObiCfg = SbrPortObiCfg,
   parameter type sbr_port_obi_req_t = obi_pkg::obi_req_t,
   parameter type sbr_port_obi_rsp_t = obi_pkg::obi_rsp_t,
   parameter type mgr_port_obi_req_t = obi_pkg::obi_req_t,
   parameter type mgr_port_obi_rsp_t = obi_pkg::obi_rsp_t,
   parameter int unsigned NumSbrPorts     = 2,
   parameter int unsigned NumMaxTrans     = 4,
   parameter int unsigned MaxTransPerPort = 2,
   parameter int unsigned ArbMode         = 0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  sbr_port_obi_req_t [NumSbrPorts-1:0]   sbr_ports_req_i,
   output sbr_port_obi_rsp_t [NumSbrPorts-1:0]   sbr_ports_rsp_o,
   output mgr_port_obi_req_t                     mgr_port_req_o,
   input  mgr_port_obi_rsp_t                     mgr_port_rsp_i,
   output logic                                  spurious_rsp_o
`ifdef OBI_MUX_QOS_PERF_CNT_EN
   ,
   output logic [NumSbrPorts-1:0][31:0]          perf_cnt_o
`endif
);

   localparam int unsigned SbrIdW    = SbrPortObiCfg.IdWidth;
   localparam int unsigned MgrIdW    = MgrPortObiCfg.IdWidth;
   localparam int unsigned IdxW      = $clog2(NumSbrPorts);
   localparam int unsigned PtrW      = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
   localparam int unsigned UsageW    = $clog2(NumMaxTrans + 1);
   localparam int unsigned CntW      = $clog2(MaxTransPerPort + 1);
   localparam bit          UseRReady = SbrPortObiCfg.UseRReady;

   if (MgrIdW < SbrIdW) begin : g_err_id
      $error("obi_mux_qos: manager IdWidth smaller than subordinate IdWidth");
   end
   if (MgrPortObiCfg.AddrWidth != SbrPortObiCfg.AddrWidth ||
       MgrPortObiCfg.DataWidth != SbrPortObiCfg.DataWidth ||
       MgrPortObiCfg.UseRReady != SbrPortObiCfg.UseRReady) begin : g_err_cfg
      $error("obi_mux_qos: manager and subordinate configs differ outside IdWidth");
   end
   if (NumSbrPorts < 2 || MaxTransPerPort < 1 || MaxTransPerPort > NumMaxTrans || ArbMode > 1) begin : g_err_param
      $error("obi_mux_qos: illegal port count, transaction limit or arbitration mode");
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + PtrW'(1);
   endfunction

   function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] p);
      return (p == IdxW'(NumSbrPorts - 1)) ? '0 : p + IdxW'(1);
   endfunction

   logic [IdxW-1:0]                  fifo_q [NumMaxTrans];
   logic [PtrW-1:0]                  wr_ptr_q, rd_ptr_q;
   logic [UsageW-1:0]                usage_q;
   logic [NumSbrPorts-1:0][CntW-1:0] cnt_q;
   logic                             lock_q;
   logic [IdxW-1:0]                  lock_idx_q, rr_ptr_q;

   logic [NumSbrPorts-1:0] eligible;
   logic [IdxW-1:0]        sel_idx, head;
   logic                   sel_vld, fifo_full, fifo_empty, mgr_req, hs, rsp_vld, pop, head_rready;
   logic [SbrIdW-1:0]      sel_aid;
   logic [MgrIdW-1:0]      mgr_aid;

   always_comb begin
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
         eligible[i] = sbr_ports_req_i[i].req && (cnt_q[i] < CntW'(MaxTransPerPort));
      end
   end

   // Locked selection holds until the pending request is granted.
   always_comb begin
      int unsigned j;
      j       = 0;
      sel_idx = '0;
      sel_vld = 1'b0;
      if (lock_q) begin
         sel_idx = lock_idx_q;
         sel_vld = sbr_ports_req_i[lock_idx_q].req;
      end else begin
         for (int unsigned k = 0; k < NumSbrPorts; k++) begin
            j = (ArbMode == 1) ? k : (32'(rr_ptr_q) + k) % NumSbrPorts;
            if (!sel_vld && eligible[IdxW'(j)]) begin
               sel_vld = 1'b1;
               sel_idx = IdxW'(j);
            end
         end
      end
   end

   assign fifo_full   = (usage_q == UsageW'(NumMaxTrans));
   assign fifo_empty  = (usage_q == '0);
   assign head        = fifo_q[rd_ptr_q];
   assign head_rready = sbr_ports_req_i[head].rready;
   assign mgr_req     = sel_vld && !fifo_full && !rst_i;
   assign hs          = mgr_req && mgr_port_rsp_i.gnt;
   assign rsp_vld     = mgr_port_rsp_i.rvalid && !fifo_empty && !rst_i;
   assign pop         = rsp_vld && (UseRReady ? head_rready : 1'b1);
   assign spurious_rsp_o = mgr_port_rsp_i.rvalid && fifo_empty && !rst_i;
   assign sel_aid     = sbr_ports_req_i[sel_idx].a.aid;

   if (MgrIdW >= SbrIdW + IdxW) begin : g_aid_prefix
      assign mgr_aid = MgrIdW'({sel_idx, sel_aid});
   end else begin : g_aid_plain
      assign mgr_aid = MgrIdW'(sel_aid);
   end

   always_comb begin
      mgr_port_req_o         = '0;
      mgr_port_req_o.req     = mgr_req;
      mgr_port_req_o.a.addr  = sbr_ports_req_i[sel_idx].a.addr;
      mgr_port_req_o.a.we    = sbr_ports_req_i[sel_idx].a.we;
      mgr_port_req_o.a.be    = sbr_ports_req_i[sel_idx].a.be;
      mgr_port_req_o.a.wdata = sbr_ports_req_i[sel_idx].a.wdata;
      mgr_port_req_o.a.aid   = mgr_aid;
      mgr_port_req_o.rready  = fifo_empty ? 1'b1 : head_rready;
   end

   // Response payload is broadcast; only rvalid is steered to the FIFO head.
   always_comb begin
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
         sbr_ports_rsp_o[i]         = '0;
         sbr_ports_rsp_o[i].gnt     = hs && (sel_idx == IdxW'(i));
         sbr_ports_rsp_o[i].rvalid  = rsp_vld && (head == IdxW'(i));
         sbr_ports_rsp_o[i].r.rdata = mgr_port_rsp_i.r.rdata;
         sbr_ports_rsp_o[i].r.rid   = mgr_port_rsp_i.r.rid[SbrIdW-1:0];
         sbr_ports_rsp_o[i].r.err   = mgr_port_rsp_i.r.err;
      end
   end

   always_ff @(posedge clk_i) begin
      if (hs) fifo_q[wr_ptr_q] <= sel_idx;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         usage_q    <= '0;
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         if (hs)  wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         usage_q    <= usage_q + UsageW'(hs) - UsageW'(pop);
         lock_q     <= mgr_req && !mgr_port_rsp_i.gnt;
         lock_idx_q <= sel_idx;
         if (ArbMode == 0 && hs) rr_ptr_q <= idx_inc(sel_idx);
         for (int unsigned i = 0; i < NumSbrPorts; i++) begin
            if (hs && sel_idx == IdxW'(i) && !(pop && head == IdxW'(i))) begin
               cnt_q[i] <= cnt_q[i] + CntW'(1);
            end else if (pop && head == IdxW'(i) && !(hs && sel_idx == IdxW'(i))) begin
               cnt_q[i] <= cnt_q[i] - CntW'(1);
            end
         end
      end
   end

`ifdef OBI_MUX_QOS_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   logic [NumSbrPorts-1:0][31:0] perf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NumSbrPorts; i++) begin
            if (hs && sel_idx == IdxW'(i)) perf_q[i] <= sat_inc(perf_q[i]);
         end
      end
   end

   assign perf_cnt_o = perf_q;
`endif

endmodule
